// File: rtl/mcu_pwm_multi_if.sv
// MCU SRAM-style write bus feeding the PWM register file (all signals asynchronous to clk).
interface mcu_pwm_multi_if #(
  parameter int ADR_WIDTH  = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  pwm_ncs;
  logic                  pwm_nwe;
  logic [ADR_WIDTH-1:0]  pwm_addr;
  logic [DATA_WIDTH-1:0] pwm_sram_data;

  modport master (output pwm_ncs, pwm_nwe, pwm_addr, pwm_sram_data);
  modport slave  (input  pwm_ncs, pwm_nwe, pwm_addr, pwm_sram_data);
endinterface

// File: rtl/mcu_pwm_multi.sv
// Multi-channel PWM with double-buffered period/duty, edge or center-aligned counting.
// Optional MCU_PWM_POLARITY_EN adds a per-channel output polarity mask (control byte 2).
module mcu_pwm_multi #(
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 24,
  parameter int ADR_WIDTH  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mcu_pwm_multi_if.slave        bus,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_tick
);
  localparam int NB = CNT_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic                  ncs_p0, ncs_p1, nwe_p0, nwe_p1;
  logic [ADR_WIDTH-1:0]  addr_p0, addr_p1, addr_cap;
  logic [DATA_WIDTH-1:0] data_p0, data_p1, data_cap;
  logic                  acc, acc_p2, commit;

  // Stage p0/p1: two-flop synchronisers; p2: last address/data seen during the access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ncs_p0   <= 1'b1;
      ncs_p1   <= 1'b1;
      nwe_p0   <= 1'b1;
      nwe_p1   <= 1'b1;
      addr_p0  <= '0;
      addr_p1  <= '0;
      data_p0  <= '0;
      data_p1  <= '0;
      addr_cap <= '0;
      data_cap <= '0;
      acc_p2   <= 1'b0;
    end else begin
      ncs_p0  <= bus.pwm_ncs;
      ncs_p1  <= ncs_p0;
      nwe_p0  <= bus.pwm_nwe;
      nwe_p1  <= nwe_p0;
      addr_p0 <= bus.pwm_addr;
      addr_p1 <= addr_p0;
      data_p0 <= bus.pwm_sram_data;
      data_p1 <= data_p0;
      acc_p2  <= acc;
      if (acc) begin
        addr_cap <= addr_p1;
        data_cap <= data_p1;
      end
    end
  end

  assign acc    = ~(ncs_p1 | nwe_p1);
  assign commit = acc_p2 & ~acc;

  logic [ADR_WIDTH-3:0] wsel;
  logic [1:0]           bsel;
  logic                 byte_ok, wr_per, wr_ctl, cm_chg;
  logic [CHANNELS-1:0]  wr_duty;

  assign wsel    = addr_cap[ADR_WIDTH-1:2];
  assign bsel    = addr_cap[1:0];
  assign byte_ok = (int'(bsel) < NB);
  assign wr_per  = commit && (wsel == '0) && byte_ok;
  assign wr_ctl  = commit && (int'(wsel) == 1);

  always_comb begin
    wr_duty = '0;
    for (int i = 0; i < CHANNELS; i++)
      wr_duty[i] = commit && byte_ok && (int'(wsel) == i + 2);
  end

  // Bytes are packed MSB first: byte 0 lands in the top 8 bits of the register
  function automatic logic [CNT_WIDTH-1:0] put_byte(input logic [CNT_WIDTH-1:0] cur,
                                                     input logic [1:0]           b,
                                                     input logic [7:0]           d);
    int sh;
    sh = 8 * (NB - 1 - ((int'(b) < NB) ? int'(b) : 0));
    return (cur & ~(CNT_WIDTH'(8'hFF) << sh)) | (CNT_WIDTH'(d) << sh);
  endfunction

  logic                 en, cm;
  logic [CHANNELS-1:0]  chen, raw;
`ifdef MCU_PWM_POLARITY_EN
  logic [CHANNELS-1:0]  pol;
`endif
  logic [CNT_WIDTH-1:0] per_sh, per_act, cnt;
  logic [CNT_WIDTH-1:0] duty_sh  [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_act [CHANNELS];
  logic                 up, boundary, load, per_zero;

  assign cm_chg = wr_ctl && (bsel == 2'd0) && (data_cap[1] != cm);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= 1'b0;
      cm   <= 1'b0;
      chen <= '0;
`ifdef MCU_PWM_POLARITY_EN
      pol  <= '0;
`endif
    end else if (wr_ctl) begin
      case (bsel)
        2'd0: begin
          en <= data_cap[0];
          cm <= data_cap[1];
        end
        2'd1: chen <= data_cap[CHANNELS-1:0];
`ifdef MCU_PWM_POLARITY_EN
        2'd2: pol  <= data_cap[CHANNELS-1:0];
`endif
        default: ;
      endcase
    end
  end

  assign per_zero = (per_act == '0);

  always_comb begin
    boundary = 1'b0;
    if (en && !per_zero)
      boundary = cm ? (!up && cnt == '0) : (cnt == per_act - ONE);
  end

  assign period_tick = boundary;
  assign load        = ~en | boundary;

  // Shadows take bus writes; actives follow shadows only at load points
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_sh  <= '0;
      per_act <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      if (wr_per) per_sh <= put_byte(per_sh, bsel, data_cap[7:0]);
      for (int i = 0; i < CHANNELS; i++)
        if (wr_duty[i]) duty_sh[i] <= put_byte(duty_sh[i], bsel, data_cap[7:0]);
      if (load) begin
        per_act <= per_sh;
        for (int i = 0; i < CHANNELS; i++) duty_act[i] <= duty_sh[i];
      end
    end
  end

  // Center mode dwells one extra cycle at each endpoint while dir flips
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      up  <= 1'b1;
    end else if (!en || cm_chg || per_zero) begin
      cnt <= '0;
      up  <= 1'b1;
    end else if (!cm) begin
      cnt <= (cnt >= per_act - ONE) ? '0 : cnt + ONE;
    end else if (up) begin
      if (cnt >= per_act - ONE) up <= 1'b0;
      else                      cnt <= cnt + ONE;
    end else begin
      if (cnt == '0) up  <= 1'b1;
      else           cnt <= cnt - ONE;
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < CHANNELS; i++)
      raw[i] = (cnt < duty_act[i]) && en && chen[i] && !per_zero;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_out <= '0;
`ifdef MCU_PWM_POLARITY_EN
    else        pwm_out <= raw ^ pol;
`else
    else        pwm_out <= raw;
`endif
  end
endmodule

// File: tb/tb_mcu_pwm_multi.sv
// Self-checking bench for mcu_pwm_multi: bus writes, a phase-based waveform model, randomized programs.
module tb_mcu_pwm_multi;
  localparam int CH = 4;
  localparam int CW = 24;
  localparam int NB = CW / 8;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  mcu_pwm_multi_if #(.ADR_WIDTH(8), .DATA_WIDTH(8)) bif ();

  mcu_pwm_multi #(.CHANNELS(CH), .CNT_WIDTH(CW), .ADR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bif),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference register model (what the MCU believes it programmed)
  int unsigned   m_per_sh, m_per_act;
  int unsigned   m_duty_sh [CH];
  int unsigned   m_duty_act[CH];
  bit            m_cm;
  bit [CH-1:0]   m_chen;
  bit [CH-1:0]   m_pol;
  int unsigned   dt[CH];

  function automatic int unsigned set_byte(input int unsigned v, input int b, input bit [7:0] d);
    int sh;
    sh = 8 * (NB - 1 - b);
    return (v & ~(32'hFF << sh)) | (32'(d) << sh);
  endfunction

  function automatic bit [7:0] byte_of(input int unsigned v, input int b);
    return 8'((v >> (8 * (NB - 1 - b))) & 32'hFF);
  endfunction

  task automatic model_write(input bit [7:0] a, input bit [7:0] d);
    int w, b;
    w = int'(a) / 4;
    b = int'(a) % 4;
    if (w == 0) begin
      if (b < NB) m_per_sh = set_byte(m_per_sh, b, d);
    end else if (w == 1) begin
      if (b == 0) m_cm = d[1];
      else if (b == 1) m_chen = d[CH-1:0];
`ifdef MCU_PWM_POLARITY_EN
      else if (b == 2) m_pol = d[CH-1:0];
`endif
    end else if (w < 2 + CH) begin
      if (b < NB) m_duty_sh[w-2] = set_byte(m_duty_sh[w-2], b, d);
    end
  endtask

  task automatic model_reset();
    m_per_sh = 0; m_per_act = 0; m_cm = 0; m_chen = '0; m_pol = '0;
    for (int i = 0; i < CH; i++) begin
      m_duty_sh[i] = 0;
      m_duty_act[i] = 0;
    end
  endtask

  task automatic wr(input bit [7:0] a, input bit [7:0] d);
    @(posedge clk); #2;
    bif.pwm_addr = a;
    bif.pwm_sram_data = d;
    bif.pwm_ncs = 1'b0;
    bif.pwm_nwe = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    bif.pwm_nwe = 1'b1;
    bif.pwm_ncs = 1'b1;
    repeat (4) @(posedge clk);
    model_write(a, d);
  endtask

  // Waveform monitor: phase within a 2P (center) or P (edge) period, anchored on the first tick
  bit            mon_on = 0, anchored = 0, last_bnd = 0;
  int            ph, len, wait_cyc, lim;
  logic [CH-1:0] exp_out;

  function automatic int cnt_at(input int phase);
    if (!m_cm) return phase;
    return (phase < int'(m_per_act)) ? phase : 2 * int'(m_per_act) - 1 - phase;
  endfunction

  function automatic logic [CH-1:0] out_at(input int c);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++)
      r[i] = ((c < int'(m_duty_act[i])) && m_chen[i]) ^ m_pol[i];
    return r;
  endfunction

  task automatic load_actives();
    m_per_act = m_per_sh;
    for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_sh[i];
    len = m_cm ? 2 * int'(m_per_act) : int'(m_per_act);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (anchored) begin
        ph = last_bnd ? 0 : ph + 1;
        chk("pwm_out", 32'(pwm_out), 32'(exp_out));
        chk("period_tick", 32'(period_tick), 32'(ph == len - 1));
        exp_out  = out_at(cnt_at(ph));
        last_bnd = (ph == len - 1);
        if (last_bnd) load_actives();
      end else if (period_tick) begin
        anchored = 1;
        load_actives();
        ph       = len - 1;
        exp_out  = out_at(cnt_at(ph));
        last_bnd = 1;
      end else begin
        wait_cyc++;
        if (wait_cyc > lim) begin
          chk("first_tick", 32'(period_tick), 32'd1);
          mon_on = 0;
        end
      end
    end
  end

  task automatic prog(input int unsigned p, input bit [CH-1:0] ce, input bit c);
    mon_on = 0;
    wr(8'h04, 8'h00);
    wr(8'h05, 8'(ce));
    for (int b = 0; b < NB; b++) wr(8'(b), byte_of(p, b));
    for (int i = 0; i < CH; i++)
      for (int b = 0; b < NB; b++) wr(8'(8 + 4 * i + b), byte_of(dt[i], b));
    wr(8'h04, {6'b0, c, 1'b1});
    anchored = 0;
    wait_cyc = 0;
    lim      = 2 * (c ? 2 * int'(p) : int'(p)) + 24;
    mon_on   = 1;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 80);
    if (!period_tick) chk("wait_tick", 32'(period_tick), 32'd1);
  endtask

  initial begin
    bif.pwm_ncs = 1'b1;
    bif.pwm_nwe = 1'b1;
    bif.pwm_addr = '0;
    bif.pwm_sram_data = '0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    chk("reset_out", 32'(pwm_out), 32'd0);
    chk("reset_tick", 32'(period_tick), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_out", 32'(pwm_out), 32'd0);

    // Edge mode, then a mid-period duty change and ignored addresses
    dt = '{4, 0, 0, 0};
    prog(16, 4'b0001, 1'b0);
    repeat (60) @(posedge clk);
    wait_tick();
    wr(8'h0A, 8'h0C);
    repeat (50) @(posedge clk);
    wr(8'h1C, 8'hFF);
    wr(8'h18, 8'hFF);
    wr(8'h03, 8'hFF);
    wr(8'h07, 8'hFF);
`ifndef MCU_PWM_POLARITY_EN
    wr(8'h06, 8'hFF);
`endif
    repeat (40) @(posedge clk);

    // Center mode
    dt = '{0, 3, 0, 0};
    prog(8, 4'b0010, 1'b1);
    repeat (70) @(posedge clk);

    // Duty boundaries: 0, above P, equal P, mid
    dt = '{0, 32, 16, 5};
    prog(16, 4'b1111, 1'b0);
    repeat (70) @(posedge clk);

    // Asynchronous reset while channels 1/2 are high
    mon_on = 0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(pwm_out), 32'd0);
    chk("async_rst_tick", 32'(period_tick), 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_out", 32'(pwm_out), 32'd0);
    end

    // P = 0 after reset: enabling alone produces nothing
    wr(8'h05, 8'h0F);
    wr(8'h0A, 8'h05);
    wr(8'h04, 8'h01);
    repeat (60) begin
      @(negedge clk);
      chk("p0_out", 32'(pwm_out), 32'd0);
      chk("p0_tick", 32'(period_tick), 32'd0);
    end

    // Randomized programs
    for (int t = 0; t < 12; t++) begin
      int unsigned p;
      bit          c;
      p = $urandom_range(1, 24);
      c = 1'($urandom_range(0, 1));
      for (int i = 0; i < CH; i++) dt[i] = $urandom_range(0, p + 3);
      prog(p, 4'($urandom_range(0, 15)), c);
      repeat (3 * (c ? 2 * p : p) + 40) @(posedge clk);
    end

`ifdef MCU_PWM_POLARITY_EN
    mon_on = 0;
    wr(8'h04, 8'h00);
    wr(8'h06, 8'h01);
    dt = '{4, 0, 0, 0};
    prog(16, 4'b0000, 1'b0);
    repeat (50) @(posedge clk);
    prog(16, 4'b0001, 1'b0);
    repeat (50) @(posedge clk);
`endif

    mon_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
